// File: rtl/hsi_frame_decoder.sv
// Oversampled serial frame decoder: start / data / optional parity / stop,
// 3-sample majority vote per bit, single-entry output register with overrun detect.
module hsi_frame_decoder #(
    parameter int DATA_W    = 8,
    parameter int OVS       = 8,
    parameter int PARITY    = 1,
    parameter int MSB_FIRST = 0
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              clk_en,
    input  logic              d,
    output logic [DATA_W-1:0] q,
    output logic              q_valid,
    input  logic              q_ack,
    output logic              pb_err,
    output logic              fr_err,
    output logic              ovr_err,
    output logic              frame_end,
    output logic              start_bit_accepted,
    output logic              busy
);

    localparam int PW = $clog2(OVS);
    localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [PW-1:0] PH_V0    = PW'(OVS / 2 - 1);
    localparam logic [PW-1:0] PH_V1    = PW'(OVS / 2);
    localparam logic [PW-1:0] PH_DEC   = PW'(OVS / 2 + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_PAR   = 3'd3;
    localparam logic [2:0] S_STOP  = 3'd4;
    localparam logic [2:0] S_BREAK = 3'd5;

    logic [2:0]        state_q, state_d;
    logic [PW-1:0]     ph_q, ph_d;
    logic [BW-1:0]     bit_q, bit_d;
    logic [1:0]        v_q, v_d;
    logic [DATA_W-1:0] sh_q, sh_d;
    logic              par_q, par_d;
    logic [DATA_W-1:0] q_q, q_d;
    logic              qv_q, qv_d;
    logic              sba_q, sba_d;
    logic              fe_q, fe_d;
    logic              pb_q, pb_d;
    logic              fr_q, fr_d;
    logic              ovr_q, ovr_d;

    logic              vote;
    logic              decide;
    logic              par_ok;
    logic [BW-1:0]     idx;

    always_comb begin
        vote   = (v_q[0] & v_q[1]) | (v_q[0] & d) | (v_q[1] & d);
        decide = clk_en && (ph_q == PH_DEC);
        if (PARITY == 0) begin
            par_ok = 1'b1;
        end else if (PARITY == 1) begin
            par_ok = (^sh_q) ^ par_q;
        end else begin
            par_ok = ~((^sh_q) ^ par_q);
        end
        idx = (MSB_FIRST != 0) ? (LAST_BIT - bit_q) : bit_q;
    end

    always_comb begin
        state_d = state_q;
        ph_d    = ph_q;
        bit_d   = bit_q;
        v_d     = v_q;
        sh_d    = sh_q;
        par_d   = par_q;
        q_d     = q_q;
        qv_d    = qv_q;
        sba_d   = 1'b0;
        fe_d    = 1'b0;
        pb_d    = 1'b0;
        fr_d    = 1'b0;
        ovr_d   = 1'b0;

        if (qv_q && q_ack) begin
            qv_d = 1'b0;
        end

        if (clk_en) begin
            ph_d = ph_q + 1'b1;
            if (ph_q == PH_V0) v_d[0] = d;
            if (ph_q == PH_V1) v_d[1] = d;

            case (state_q)
                S_IDLE: begin
                    ph_d = '0;
                    if (!d) begin
                        // The falling-edge tick itself is phase 0.
                        state_d = S_START;
                        ph_d    = PW'(1);
                    end
                end
                S_START: begin
                    if (decide) begin
                        if (vote) begin
                            state_d = S_IDLE;
                            ph_d    = '0;
                        end else begin
                            state_d = S_DATA;
                            bit_d   = '0;
                            sba_d   = 1'b1;
                        end
                    end
                end
                S_DATA: begin
                    if (decide) begin
                        sh_d[idx] = vote;
                        if (bit_q == LAST_BIT) begin
                            state_d = (PARITY != 0) ? S_PAR : S_STOP;
                        end else begin
                            bit_d = bit_q + 1'b1;
                        end
                    end
                end
                S_PAR: begin
                    if (decide) begin
                        par_d   = vote;
                        state_d = S_STOP;
                    end
                end
                S_STOP: begin
                    if (decide) begin
                        pb_d = ~par_ok;
                        if (vote) begin
                            fe_d    = 1'b1;
                            state_d = S_IDLE;
                            ph_d    = '0;
                            if (par_ok) begin
                                // A load together with q_ack replaces the word instead of overrunning.
                                if (qv_q && !q_ack) begin
                                    ovr_d = 1'b1;
                                end else begin
                                    q_d  = sh_q;
                                    qv_d = 1'b1;
                                end
                            end
                        end else begin
                            fr_d    = 1'b1;
                            state_d = S_BREAK;
                        end
                    end
                end
                S_BREAK: begin
                    if (d) begin
                        state_d = S_IDLE;
                        ph_d    = '0;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    ph_d    = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= S_IDLE;
            ph_q    <= '0;
            bit_q   <= '0;
            v_q     <= '0;
            sh_q    <= '0;
            par_q   <= 1'b0;
            q_q     <= '0;
            qv_q    <= 1'b0;
            sba_q   <= 1'b0;
            fe_q    <= 1'b0;
            pb_q    <= 1'b0;
            fr_q    <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ph_q    <= ph_d;
            bit_q   <= bit_d;
            v_q     <= v_d;
            sh_q    <= sh_d;
            par_q   <= par_d;
            q_q     <= q_d;
            qv_q    <= qv_d;
            sba_q   <= sba_d;
            fe_q    <= fe_d;
            pb_q    <= pb_d;
            fr_q    <= fr_d;
            ovr_q   <= ovr_d;
        end
    end

    assign q                  = q_q;
    assign q_valid            = qv_q;
    assign pb_err             = pb_q;
    assign fr_err             = fr_q;
    assign ovr_err            = ovr_q;
    assign frame_end          = fe_q;
    assign start_bit_accepted = sba_q;
    assign busy               = (state_q != S_IDLE);

endmodule

// File: tb/tb_hsi_frame_decoder.sv
// Bench for hsi_frame_decoder: tick streams are decoded by a frame-level model
// (array indexing + majority of three samples) and compared with the DUT tick by tick.
module tb_hsi_frame_decoder;

    localparam int MAXT   = 3000;
    localparam int EV_SBA = 4;
    localparam int EV_FE  = 3;
    localparam int EV_PB  = 2;
    localparam int EV_FR  = 1;
    localparam int EV_OVR = 0;

    logic clk = 1'b0;
    logic n_rst, clk_en, d, q_ack;

    logic [7:0] q0;
    logic       qv0, pb0, fr0, ov0, fe0, sb0, bz0;
    logic [4:0] q1;
    logic       qv1, pb1, fr1, ov1, fe1, sb1, bz1;

    hsi_frame_decoder #(.DATA_W(8), .OVS(8), .PARITY(1), .MSB_FIRST(0)) dut0 (
        .clk(clk), .n_rst(n_rst), .clk_en(clk_en), .d(d),
        .q(q0), .q_valid(qv0), .q_ack(q_ack),
        .pb_err(pb0), .fr_err(fr0), .ovr_err(ov0),
        .frame_end(fe0), .start_bit_accepted(sb0), .busy(bz0)
    );

    hsi_frame_decoder #(.DATA_W(5), .OVS(4), .PARITY(2), .MSB_FIRST(1)) dut1 (
        .clk(clk), .n_rst(n_rst), .clk_en(clk_en), .d(d),
        .q(q1), .q_valid(qv1), .q_ack(q_ack),
        .pb_err(pb1), .fr_err(fr1), .ovr_err(ov1),
        .frame_end(fe1), .start_bit_accepted(sb1), .busy(bz1)
    );

    always #5 clk = ~clk;

    int sel;
    logic [4:0] cur_ev;
    int         cur_q;
    logic       cur_qv, cur_bz;

    always_comb begin
        if (sel == 0) begin
            cur_ev = {sb0, fe0, pb0, fr0, ov0};
            cur_q  = int'(q0);
            cur_qv = qv0;
            cur_bz = bz0;
        end else begin
            cur_ev = {sb1, fe1, pb1, fr1, ov1};
            cur_q  = int'(q1);
            cur_qv = qv1;
            cur_bz = bz1;
        end
    end

    bit         d_arr   [MAXT];
    bit         ack_arr [MAXT];
    int         ld_arr  [MAXT];
    logic [4:0] obs_ev  [MAXT];
    logic [4:0] exp_ev  [MAXT];
    int         obs_q   [MAXT];
    int         exp_q   [MAXT];
    logic       obs_qv  [MAXT];
    logic       exp_qv  [MAXT];
    logic       obs_bz  [MAXT];
    logic       exp_bz  [MAXT];
    int slen, gap_bad, first_bad;
    int m_dw, m_ovs, m_par, m_msb;
    int tests = 0;
    int fails = 0;

    task automatic use_dut(input int s);
        sel = s;
        if (s == 0) begin m_dw = 8; m_ovs = 8; m_par = 1; m_msb = 0; end
        else        begin m_dw = 5; m_ovs = 4; m_par = 2; m_msb = 1; end
        slen = 0;
    endtask

    task automatic put(input bit b, input int n);
        for (int i = 0; i < n; i++) begin
            d_arr[slen] = b; ack_arr[slen] = 1'b0; slen++;
        end
    endtask

    // pbit < 0 means no parity bit is transmitted
    task automatic put_frame(input int word, input int pbit, input bit stop);
        put(1'b0, m_ovs);
        for (int k = 0; k < m_dw; k++) begin
            int idx = (m_msb != 0) ? m_dw - 1 - k : k;
            put(bit'((word >> idx) & 1), m_ovs);
        end
        if (pbit >= 0) put(bit'(pbit), m_ovs);
        put(stop, m_ovs);
    endtask

    function automatic int good_par(input int word);
        int ones = $countones(word & ((1 << m_dw) - 1));
        if (m_par == 1) return (ones % 2 == 0) ? 1 : 0;
        return ones % 2;
    endfunction

    function automatic bit maj(input int c);
        int n = int'(d_arr[c - 2]) + int'(d_arr[c - 1]) + int'(d_arr[c]);
        return n >= 2;
    endfunction

    task automatic mark_busy(input int a, input int b);
        for (int t = a; t <= b; t++) exp_bz[t] = 1'b1;
    endtask

    task automatic run_model();
        int pos, s, m, p, dec, ts, e, word, ones, valid, qv;
        bit b, pok;
        m = m_ovs / 2;
        p = (m_par > 0) ? 1 : 0;
        for (int t = 0; t < slen; t++) begin
            exp_ev[t] = '0; exp_bz[t] = 1'b0; ld_arr[t] = -1;
        end
        pos = 0;
        while (pos < slen) begin
            if (d_arr[pos]) begin pos++; continue; end
            s   = pos;
            dec = s + m + 1;
            if (dec >= slen) begin mark_busy(s, slen - 1); break; end
            if (maj(dec)) begin mark_busy(s, dec - 1); pos = dec + 1; continue; end
            exp_ev[dec][EV_SBA] = 1'b1;
            ts = s + (1 + m_dw + p) * m_ovs + m + 1;
            if (ts >= slen) begin mark_busy(s, slen - 1); break; end
            word = 0; ones = 0;
            for (int k = 0; k < m_dw; k++) begin
                b = maj(s + (1 + k) * m_ovs + m + 1);
                word |= int'(b) << ((m_msb != 0) ? m_dw - 1 - k : k);
                ones += int'(b);
            end
            if (p == 1) ones += int'(maj(s + (1 + m_dw) * m_ovs + m + 1));
            pok = (m_par == 0) || (m_par == 1 && ones % 2 == 1) || (m_par == 2 && ones % 2 == 0);
            if (!pok) exp_ev[ts][EV_PB] = 1'b1;
            if (maj(ts)) begin
                exp_ev[ts][EV_FE] = 1'b1;
                if (pok) ld_arr[ts] = word;
                mark_busy(s, ts - 1);
                pos = ts + 1;
            end else begin
                exp_ev[ts][EV_FR] = 1'b1;
                e = ts + 1;
                while (e < slen && !d_arr[e]) e++;
                if (e >= slen) begin mark_busy(s, slen - 1); break; end
                mark_busy(s, e - 1);
                pos = e + 1;
            end
        end
        valid = 0; qv = 0;
        for (int t = 0; t < slen; t++) begin
            if (ld_arr[t] >= 0) begin
                if (qv != 0 && !ack_arr[t]) exp_ev[t][EV_OVR] = 1'b1;
                else begin valid = ld_arr[t]; qv = 1; end
            end else if (ack_arr[t] && qv != 0) begin
                qv = 0;
            end
            exp_q[t]  = valid;
            exp_qv[t] = (qv != 0);
        end
    endtask

    task automatic do_reset();
        n_rst = 1'b0; clk_en = 1'b0; d = 1'b1; q_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1 n_rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_stream(input int maxgap);
        int g;
        gap_bad = 0;
        for (int t = 0; t < slen; t++) begin
            d = d_arr[t]; q_ack = ack_arr[t]; clk_en = 1'b1;
            @(posedge clk);
            #1;
            obs_ev[t] = cur_ev; obs_q[t] = cur_q; obs_qv[t] = cur_qv; obs_bz[t] = cur_bz;
            clk_en = 1'b0; q_ack = 1'b0;
            g = $urandom_range(maxgap, 0);
            repeat (g) begin
                @(posedge clk);
                #1;
                if (cur_ev !== 5'b0) gap_bad++;
            end
        end
        d = 1'b1;
    endtask

    function automatic int stream_mismatches();
        int n = gap_bad;
        first_bad = -1;
        for (int t = 0; t < slen; t++) begin
            if (obs_ev[t] !== exp_ev[t] || obs_qv[t] !== exp_qv[t] ||
                obs_bz[t] !== exp_bz[t] || obs_q[t] != exp_q[t]) begin
                n++;
                if (first_bad < 0) first_bad = t;
            end
        end
        return n;
    endfunction

    function automatic string first_diff();
        int t = (first_bad < 0) ? 0 : first_bad;
        return $sformatf("tick %0d ev got %b want %b, qv got %b want %b, q got %0h want %0h, busy got %b want %b, pulses between ticks %0d",
                         t, obs_ev[t], exp_ev[t], obs_qv[t], exp_qv[t], obs_q[t], exp_q[t],
                         obs_bz[t], exp_bz[t], gap_bad);
    endfunction

    function automatic int first_ev(input int b);
        for (int t = 0; t < slen; t++) if (obs_ev[t][b] === 1'b1) return t;
        return -1;
    endfunction

    function automatic int count_ev(input int b);
        int n = 0;
        for (int t = 0; t < slen; t++) if (obs_ev[t][b] === 1'b1) n++;
        return n;
    endfunction

    task automatic test_reset();
        n_rst = 1'b1; clk_en = 1'b0; d = 1'b1; q_ack = 1'b0;
        @(posedge clk);
        #3 n_rst = 1'b0;
        #1;
        tests++; if ({q0, qv0, bz0} !== 10'b0) begin fails++; $display("FAIL reset_dut0_q_qv_busy: got %h/%b/%b want 0/0/0", q0, qv0, bz0); end
        tests++; if ({sb0, fe0, pb0, fr0, ov0} !== 5'b0) begin fails++; $display("FAIL reset_dut0_pulses: got %b want 00000", {sb0, fe0, pb0, fr0, ov0}); end
        tests++; if ({q1, qv1, bz1} !== 7'b0) begin fails++; $display("FAIL reset_dut1_q_qv_busy: got %h/%b/%b want 0/0/0", q1, qv1, bz1); end
        do_reset();
    endtask

    task automatic test_basic_frame();
        int s, mm;
        do_reset(); use_dut(0);
        put(1'b1, 3); s = slen;
        put_frame('hA5, 1, 1'b1); put(1'b1, 10);
        ack_arr[s + 90] = 1'b1;
        run_model(); drive_stream(2);
        tests++; if (first_ev(EV_SBA) - s != 5) begin fails++; $display("FAIL basic_start_tick: got %0d want 5", first_ev(EV_SBA) - s); end
        tests++; if (first_ev(EV_FE) - s != 85) begin fails++; $display("FAIL basic_stop_tick: got %0d want 85", first_ev(EV_FE) - s); end
        tests++; if (obs_q[s + 85] != 'hA5 || obs_qv[s + 85] !== 1'b1) begin fails++; $display("FAIL basic_load: got q %0h qv %b want a5 1", obs_q[s + 85], obs_qv[s + 85]); end
        tests++; if (obs_qv[s + 84] !== 1'b0) begin fails++; $display("FAIL basic_qv_early: got %b want 0", obs_qv[s + 84]); end
        tests++; if (obs_qv[s + 89] !== 1'b1 || obs_qv[s + 90] !== 1'b0) begin fails++; $display("FAIL basic_ack_clear: got %b%b want 10", obs_qv[s + 89], obs_qv[s + 90]); end
        tests++; if (count_ev(EV_PB) + count_ev(EV_FR) + count_ev(EV_OVR) != 0) begin fails++; $display("FAIL basic_no_errors: got %0d error pulses want 0", count_ev(EV_PB) + count_ev(EV_FR) + count_ev(EV_OVR)); end
        mm = stream_mismatches();
        tests++; if (mm != 0) begin fails++; $display("FAIL basic_model: %0d bad ticks, first %s", mm, first_diff()); end
    endtask

    task automatic test_start_glitch();
        int s, mm;
        do_reset(); use_dut(0);
        put(1'b1, 2); s = slen;
        put(1'b0, 2); put(1'b1, 12);
        run_model(); drive_stream(1);
        tests++; if (count_ev(EV_SBA) != 0) begin fails++; $display("FAIL glitch_no_start: got %0d pulses want 0", count_ev(EV_SBA)); end
        tests++; if (obs_bz[s + 4] !== 1'b1 || obs_bz[s + 5] !== 1'b0) begin fails++; $display("FAIL glitch_busy_drop: got %b%b want 10", obs_bz[s + 4], obs_bz[s + 5]); end
        mm = stream_mismatches();
        tests++; if (mm != 0) begin fails++; $display("FAIL glitch_model: %0d bad ticks, first %s", mm, first_diff()); end
    endtask

    task automatic test_parity_err();
        int s, mm, nqv;
        do_reset(); use_dut(0);
        put(1'b1, 2); s = slen;
        put_frame('hA5, 0, 1'b1); put(1'b1, 6);
        run_model(); drive_stream(2);
        nqv = 0;
        for (int t = 0; t < slen; t++) if (obs_qv[t] !== 1'b0) nqv++;
        tests++; if (obs_ev[s + 85][EV_PB] !== 1'b1 || obs_ev[s + 85][EV_FE] !== 1'b1) begin fails++; $display("FAIL parity_pulses: got pb %b fe %b want 1 1", obs_ev[s + 85][EV_PB], obs_ev[s + 85][EV_FE]); end
        tests++; if (nqv != 0) begin fails++; $display("FAIL parity_no_load: got %0d valid ticks want 0", nqv); end
        mm = stream_mismatches();
        tests++; if (mm != 0) begin fails++; $display("FAIL parity_model: %0d bad ticks, first %s", mm, first_diff()); end
    endtask

    task automatic test_overrun();
        int s2, mm;
        for (int pass = 0; pass < 2; pass++) begin
            do_reset(); use_dut(0);
            put(1'b1, 2);
            put_frame('h11, good_par('h11), 1'b1); put(1'b1, 6);
            s2 = slen;
            put_frame('h22, good_par('h22), 1'b1); put(1'b1, 6);
            if (pass == 1) ack_arr[s2 + 85] = 1'b1;
            run_model(); drive_stream(2);
            if (pass == 0) begin
                tests++; if (obs_ev[s2 + 85][EV_OVR] !== 1'b1) begin fails++; $display("FAIL overrun_pulse: got %b want 1", obs_ev[s2 + 85][EV_OVR]); end
                tests++; if (obs_q[slen - 1] != 'h11 || obs_qv[slen - 1] !== 1'b1) begin fails++; $display("FAIL overrun_keep: got q %0h qv %b want 11 1", obs_q[slen - 1], obs_qv[slen - 1]); end
            end else begin
                tests++; if (count_ev(EV_OVR) != 0) begin fails++; $display("FAIL ack_load_no_ovr: got %0d pulses want 0", count_ev(EV_OVR)); end
                tests++; if (obs_q[s2 + 85] != 'h22 || obs_qv[s2 + 85] !== 1'b1) begin fails++; $display("FAIL ack_load_word: got q %0h qv %b want 22 1", obs_q[s2 + 85], obs_qv[s2 + 85]); end
            end
            mm = stream_mismatches();
            tests++; if (mm != 0) begin fails++; $display("FAIL overrun_model_%0d: %0d bad ticks, first %s", pass, mm, first_diff()); end
        end
    endtask

    task automatic test_break();
        int s, mm;
        do_reset(); use_dut(0);
        put(1'b1, 2); s = slen;
        put(1'b0, 160); put(1'b1, 10);
        run_model(); drive_stream(1);
        tests++; if (count_ev(EV_FR) != 1 || obs_ev[s + 85][EV_FR] !== 1'b1) begin fails++; $display("FAIL break_one_fr: got %0d pulses first at %0d want 1 at 85", count_ev(EV_FR), first_ev(EV_FR) - s); end
        tests++; if (obs_bz[s + 159] !== 1'b1 || obs_bz[s + 160] !== 1'b0) begin fails++; $display("FAIL break_busy: got %b%b want 10", obs_bz[s + 159], obs_bz[s + 160]); end
        tests++; if (count_ev(EV_FE) != 0) begin fails++; $display("FAIL break_no_frame_end: got %0d want 0", count_ev(EV_FE)); end
        mm = stream_mismatches();
        tests++; if (mm != 0) begin fails++; $display("FAIL break_model: %0d bad ticks, first %s", mm, first_diff()); end
    endtask

    task automatic test_msb_first();
        int s, s2, mm;
        do_reset(); use_dut(1);
        put(1'b1, 2); s = slen;
        put_frame('b10110, 1, 1'b1); put(1'b1, 4);
        ack_arr[slen - 1] = 1'b1;
        s2 = slen;
        put_frame('b10110, 1, 1'b1); put(1'b1, 4);
        d_arr[s2 + 10] = 1'b1;  // mid-window flip inside the second transmitted bit (a 0)
        run_model(); drive_stream(2);
        tests++; if (obs_q[s + 31] != 'b10110 || obs_qv[s + 31] !== 1'b1) begin fails++; $display("FAIL msb_first_word: got q %0h qv %b want 16 1", obs_q[s + 31], obs_qv[s + 31]); end
        tests++; if (obs_q[s2 + 31] != 'b10110 || obs_qv[s2 + 31] !== 1'b1 || count_ev(EV_PB) != 0) begin fails++; $display("FAIL msb_vote_word: got q %0h qv %b pb %0d want 16 1 0", obs_q[s2 + 31], obs_qv[s2 + 31], count_ev(EV_PB)); end
        mm = stream_mismatches();
        tests++; if (mm != 0) begin fails++; $display("FAIL msb_model: %0d bad ticks, first %s", mm, first_diff()); end
    endtask

    task automatic test_reset_midframe();
        int mm;
        do_reset(); use_dut(0);
        put(1'b1, 2);
        put_frame('h3C, good_par('h3C), 1'b1); put(1'b1, 4);
        put(1'b0, 8); put(1'b1, 24);
        drive_stream(0);
        tests++; if (obs_bz[slen - 1] !== 1'b1 || obs_qv[slen - 1] !== 1'b1) begin fails++; $display("FAIL midframe_pre: got busy %b qv %b want 1 1", obs_bz[slen - 1], obs_qv[slen - 1]); end
        #2 n_rst = 1'b0;
        #1;
        tests++; if ({bz0, qv0, q0, sb0, fe0, pb0, fr0, ov0} !== 15'b0) begin fails++; $display("FAIL midframe_async_reset: got busy %b qv %b q %h pulses %b want all 0", bz0, qv0, q0, {sb0, fe0, pb0, fr0, ov0}); end
        repeat (2) @(posedge clk);
        #1 n_rst = 1'b1;
        slen = 0;
        put(1'b1, 3);
        put_frame('h5A, good_par('h5A), 1'b1); put(1'b1, 6);
        run_model(); drive_stream(1);
        mm = stream_mismatches();
        tests++; if (mm != 0 || obs_q[slen - 1] != 'h5A) begin fails++; $display("FAIL midframe_restart: %0d bad ticks, final q %0h want 5a, first %s", mm, obs_q[slen - 1], first_diff()); end
    endtask

    task automatic test_random();
        int mm, word, kind, pb, s;
        for (int round = 0; round < 4; round++) begin
            do_reset(); use_dut(round % 2);
            put(1'b1, 2);
            for (int f = 0; f < 8; f++) begin
                kind = $urandom_range(9, 0);
                word = $urandom_range((1 << m_dw) - 1, 0);
                pb   = good_par(word);
                if (kind == 0) begin
                    put(1'b0, $urandom_range(m_ovs / 2 - 1, 1));
                    put(1'b1, m_ovs);
                end else if (kind == 1) begin
                    put_frame(word, pb, 1'b0);
                    put(1'b0, $urandom_range(20, 0));
                end else begin
                    s = slen;
                    put_frame(word, (kind == 2) ? 1 - pb : pb, 1'b1);
                    if (kind == 3) begin
                        int fl = s + m_ovs + $urandom_range(m_dw * m_ovs - 1, 0);
                        d_arr[fl] = ~d_arr[fl];
                    end
                end
                put(1'b1, $urandom_range(2 * m_ovs, 1));
            end
            for (int t = 0; t < slen; t++) ack_arr[t] = ($urandom_range(5, 0) == 0);
            run_model(); drive_stream(2);
            mm = stream_mismatches();
            tests++; if (mm != 0) begin fails++; $display("FAIL random_round_%0d: %0d bad ticks, first %s", round, mm, first_diff()); end
        end
    endtask

    initial begin
        sel = 0;
        test_reset();
        test_basic_frame();
        test_start_glitch();
        test_parity_err();
        test_overrun();
        test_break();
        test_msb_first();
        test_reset_midframe();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
